// File: rtl/g3f_phase_mon.sv
// g3f_phase_mon: monitors the phase order of the three g3f phase inputs.
//
// Each phase input passes through a 2-flop synchronizer and a 1-flop edge register, so a
// rising edge is acted on at the 3rd clk edge after the input rises. A small FSM tracks the
// order of the edges. It locks to forward (A->B->C) or reverse (A->C->B) order after LOCK_N
// consecutive in-order edges. It flags repeated or simultaneous edges as glitches. A
// watchdog declares loss after TMO_CYC cycles without any phase edge.
//
// Optional feature: define G3F_MON_PERIOD_EN to measure the qa period in clk cycles. Without
// the macro, period and period_vld are tied to zero.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   en         - monitor enable; low holds all state at reset values
//   qa/qb/qc   - asynchronous phase inputs
//   seq_fwd    - locked to forward order
//   seq_rev    - locked to reverse order
//   loss       - no phase edge for TMO_CYC cycles
//   glitch     - one-cycle pulse on a repeated or simultaneous edge
//   period     - clk cycles between the last two qa edges (macro only, else 0)
//   period_vld - one-cycle pulse when period updates (macro only, else 0)
module g3f_phase_mon #(
    parameter int unsigned TMO_CYC = 1024,
    parameter int unsigned LOCK_N  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        qa,
    input  logic        qb,
    input  logic        qc,
    output logic        seq_fwd,
    output logic        seq_rev,
    output logic        loss,
    output logic        glitch,
    output logic [15:0] period,
    output logic        period_vld
);

    typedef enum logic [2:0] {StIdle, StTrackFwd, StTrackRev, StLockFwd, StLockRev} state_e;
    typedef enum logic [1:0] {PhNone, PhA, PhB, PhC} phase_e;

    function automatic phase_e fwd_of(input phase_e p);
        case (p)
            PhA:     return PhB;
            PhB:     return PhC;
            PhC:     return PhA;
            default: return PhNone;
        endcase
    endfunction

    function automatic phase_e rev_of(input phase_e p);
        case (p)
            PhA:     return PhC;
            PhC:     return PhB;
            PhB:     return PhA;
            default: return PhNone;
        endcase
    endfunction

    logic [2:0]  sync1_q, sync2_q, edge_q;
    logic [2:0]  rise;
    state_e      state_q, state_d;
    phase_e      last_q, last_d, rise_ph;
    logic [3:0]  run_q, run_d;
    logic [15:0] wd_q, wd_d;
    logic        loss_q, loss_d, glitch_q, glitch_d;
    logic        single, multi, bad_ev, loss_hit;

    assign rise     = sync2_q & ~edge_q;
    assign multi    = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
    assign single   = (rise != 3'b000) & ~multi;
    // A repeated phase counts as illegal as well as simultaneous phases.
    assign bad_ev   = multi | (single & (rise_ph == last_q));
    assign wd_d     = (rise != 3'b000) ? 16'd0 :
                      (wd_q == 16'(TMO_CYC)) ? wd_q : wd_q + 16'd1;
    assign loss_hit = (wd_d == 16'(TMO_CYC));

    always_comb begin
        rise_ph = PhNone;
        case (rise)
            3'b001:  rise_ph = PhA;
            3'b010:  rise_ph = PhB;
            3'b100:  rise_ph = PhC;
            default: rise_ph = PhNone;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            edge_q   <= '0;
            state_q  <= StIdle;
            last_q   <= PhNone;
            run_q    <= '0;
            wd_q     <= '0;
            loss_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            sync1_q  <= {qc, qb, qa};
            sync2_q  <= sync1_q;
            edge_q   <= sync2_q;
            state_q  <= state_d;
            last_q   <= last_d;
            run_q    <= run_d;
            wd_q     <= wd_d;
            loss_q   <= loss_d;
            glitch_q <= glitch_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        run_d    = run_q;
        loss_d   = loss_q;
        glitch_d = 1'b0;
        if (bad_ev) begin
            glitch_d = 1'b1;
            state_d  = StIdle;
            last_d   = PhNone;
            run_d    = '0;
        end else if (single) begin
            loss_d = 1'b0;
            last_d = rise_ph;
            if (last_q == PhNone) begin
                state_d = StIdle;
                run_d   = '0;
            end else if (rise_ph == fwd_of(last_q)) begin
                if (state_q == StTrackFwd || state_q == StLockFwd) begin
                    run_d = (run_q == 4'd15) ? run_q : run_q + 4'd1;
                    if (state_q == StTrackFwd && run_d >= 4'(LOCK_N)) state_d = StLockFwd;
                end else begin
                    state_d = StTrackFwd;
                    run_d   = 4'd1;
                end
            end else if (rise_ph == rev_of(last_q)) begin
                if (state_q == StTrackRev || state_q == StLockRev) begin
                    run_d = (run_q == 4'd15) ? run_q : run_q + 4'd1;
                    if (state_q == StTrackRev && run_d >= 4'(LOCK_N)) state_d = StLockRev;
                end else begin
                    state_d = StTrackRev;
                    run_d   = 4'd1;
                end
            end
        end
        if (loss_hit) begin
            loss_d  = 1'b1;
            state_d = StIdle;
            last_d  = PhNone;
            run_d   = '0;
        end
    end

    // Outputs.
    always_comb begin
        seq_fwd = (state_q == StLockFwd);
        seq_rev = (state_q == StLockRev);
        loss    = loss_q;
        glitch  = glitch_q;
    end

`ifdef G3F_MON_PERIOD_EN
    logic [15:0] per_cnt_q, per_cnt_d, period_q, period_d;
    logic        per_ref_q, per_ref_d, per_vld_q, per_vld_d;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            per_cnt_q <= '0;
            period_q  <= '0;
            per_ref_q <= 1'b0;
            per_vld_q <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            per_ref_q <= per_ref_d;
            per_vld_q <= per_vld_d;
        end
    end

    // per_ref_q marks that a valid reference qa edge exists to measure from.
    always_comb begin
        per_cnt_d = (per_cnt_q == 16'hFFFF) ? per_cnt_q : per_cnt_q + 16'd1;
        period_d  = period_q;
        per_ref_d = per_ref_q;
        per_vld_d = 1'b0;
        if (bad_ev) begin
            per_ref_d = 1'b0;
        end else if (single && rise[0]) begin
            per_cnt_d = 16'd1;
            per_ref_d = 1'b1;
            if (per_ref_q) begin
                period_d  = per_cnt_q;
                per_vld_d = 1'b1;
            end
        end
        if (loss_hit) per_ref_d = 1'b0;
    end

    assign period     = period_q;
    assign period_vld = per_vld_q;
`else
    assign period     = 16'd0;
    assign period_vld = 1'b0;
`endif

endmodule

// File: tb/tb_g3f_phase_mon.sv
// Directed bench for g3f_phase_mon with TMO_CYC=64, LOCK_N=3; phase edges 10 clk apart.
module tb_g3f_phase_mon;

    logic        clk = 1'b0;
    logic        rst, en, qa, qb, qc;
    logic        seq_fwd, seq_rev, loss, glitch, period_vld;
    logic [15:0] period;
    int          total = 0;
    int          bad = 0;

`ifdef G3F_MON_PERIOD_EN
    localparam logic [15:0] ExpPer = 16'd30;
    localparam logic        ExpVld = 1'b1;
`else
    localparam logic [15:0] ExpPer = 16'd0;
    localparam logic        ExpVld = 1'b0;
`endif

    g3f_phase_mon #(.TMO_CYC(64), .LOCK_N(3)) dut (
        .clk(clk), .rst(rst), .en(en), .qa(qa), .qb(qb), .qc(qc),
        .seq_fwd(seq_fwd), .seq_rev(seq_rev), .loss(loss), .glitch(glitch),
        .period(period), .period_vld(period_vld)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One-cycle input pulse; returns at the negedge just after the edge is acted on.
    task automatic fire(input logic a, input logic b, input logic c);
        @(negedge clk);
        qa = a; qb = b; qc = c;
        @(negedge clk);
        qa = 1'b0; qb = 1'b0; qc = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; qa = 1'b0; qb = 1'b0; qc = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);
        total++; if (seq_fwd !== 1'b0) begin bad++; $display("FAIL rst_seq_fwd got=%b exp=0", seq_fwd); end
        total++; if (seq_rev !== 1'b0) begin bad++; $display("FAIL rst_seq_rev got=%b exp=0", seq_rev); end
        total++; if (loss !== 1'b0) begin bad++; $display("FAIL rst_loss got=%b exp=0", loss); end
        total++; if (glitch !== 1'b0) begin bad++; $display("FAIL rst_glitch got=%b exp=0", glitch); end
        total++; if (period !== 16'd0) begin bad++; $display("FAIL rst_period got=%0d exp=0", period); end
        total++; if (period_vld !== 1'b0) begin bad++; $display("FAIL rst_pvld got=%b exp=0", period_vld); end
    endtask

    task automatic test_forward;
        fire(1, 0, 0);
        total++; if (period_vld !== 1'b0) begin bad++; $display("FAIL fwd_first_qa_pvld got=%b exp=0", period_vld); end
        idle(6); fire(0, 1, 0); idle(6); fire(0, 0, 1);
        total++; if (seq_fwd !== 1'b0) begin bad++; $display("FAIL fwd_early_lock got=%b exp=0", seq_fwd); end
        idle(6); fire(1, 0, 0);
        total++; if (seq_fwd !== 1'b1) begin bad++; $display("FAIL fwd_lock got=%b exp=1", seq_fwd); end
        total++; if (seq_rev !== 1'b0) begin bad++; $display("FAIL fwd_rev got=%b exp=0", seq_rev); end
        total++; if (loss !== 1'b0) begin bad++; $display("FAIL fwd_loss got=%b exp=0", loss); end
        total++; if (period_vld !== ExpVld) begin bad++; $display("FAIL fwd_pvld got=%b exp=%b", period_vld, ExpVld); end
        total++; if (period !== ExpPer) begin bad++; $display("FAIL fwd_period got=%0d exp=%0d", period, ExpPer); end
        idle(1);
        total++; if (period_vld !== 1'b0) begin bad++; $display("FAIL fwd_pvld_pulse got=%b exp=0", period_vld); end
    endtask

    task automatic test_reversal;
        idle(5); fire(0, 0, 1);
        total++; if (seq_fwd !== 1'b0) begin bad++; $display("FAIL rev_fwd_drop got=%b exp=0", seq_fwd); end
        idle(6); fire(0, 1, 0);
        total++; if (seq_rev !== 1'b0) begin bad++; $display("FAIL rev_early got=%b exp=0", seq_rev); end
        idle(6); fire(1, 0, 0);
        total++; if (seq_rev !== 1'b1) begin bad++; $display("FAIL rev_lock got=%b exp=1", seq_rev); end
        total++; if (seq_fwd !== 1'b0) begin bad++; $display("FAIL rev_fwd got=%b exp=0", seq_fwd); end
    endtask

    task automatic test_loss;
        idle(6); fire(0, 1, 0); idle(6); fire(0, 0, 1); idle(6); fire(1, 0, 0);
        total++; if (seq_fwd !== 1'b1) begin bad++; $display("FAIL loss_relock got=%b exp=1", seq_fwd); end
        idle(63);
        total++; if (loss !== 1'b0) begin bad++; $display("FAIL loss_early got=%b exp=0", loss); end
        total++; if (seq_fwd !== 1'b1) begin bad++; $display("FAIL loss_early_fwd got=%b exp=1", seq_fwd); end
        idle(1);
        total++; if (loss !== 1'b1) begin bad++; $display("FAIL loss_set got=%b exp=1", loss); end
        total++; if (seq_fwd !== 1'b0) begin bad++; $display("FAIL loss_fwd got=%b exp=0", seq_fwd); end
        fire(0, 1, 0);
        total++; if (loss !== 1'b0) begin bad++; $display("FAIL loss_clear got=%b exp=0", loss); end
    endtask

    task automatic test_glitch;
        idle(6); fire(1, 1, 0);
        total++; if (glitch !== 1'b1) begin bad++; $display("FAIL glitch_pulse got=%b exp=1", glitch); end
        total++; if (period_vld !== 1'b0) begin bad++; $display("FAIL glitch_pvld got=%b exp=0", period_vld); end
        idle(1);
        total++; if (glitch !== 1'b0) begin bad++; $display("FAIL glitch_width got=%b exp=0", glitch); end
        idle(5); fire(0, 0, 1); idle(6); fire(1, 0, 0);
        total++; if (period_vld !== 1'b0) begin bad++; $display("FAIL glitch_qa_pvld got=%b exp=0", period_vld); end
        idle(6); fire(0, 1, 0);
        total++; if (seq_fwd !== 1'b0) begin bad++; $display("FAIL glitch_early got=%b exp=0", seq_fwd); end
        idle(6); fire(0, 0, 1);
        total++; if (seq_fwd !== 1'b1) begin bad++; $display("FAIL glitch_relock got=%b exp=1", seq_fwd); end
        idle(6); fire(0, 0, 1);
        total++; if (glitch !== 1'b1) begin bad++; $display("FAIL repeat_glitch got=%b exp=1", glitch); end
        total++; if (seq_fwd !== 1'b0) begin bad++; $display("FAIL repeat_fwd got=%b exp=0", seq_fwd); end
    endtask

    task automatic lock_fwd;
        idle(6); fire(1, 0, 0); idle(6); fire(0, 1, 0); idle(6); fire(0, 0, 1);
        idle(6); fire(1, 0, 0);
    endtask

    task automatic test_reset_midlock;
        lock_fwd();
        total++; if (seq_fwd !== 1'b1) begin bad++; $display("FAIL mid_lock got=%b exp=1", seq_fwd); end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        total++; if (seq_fwd !== 1'b0) begin bad++; $display("FAIL mid_rst_fwd got=%b exp=0", seq_fwd); end
        total++; if (seq_rev !== 1'b0) begin bad++; $display("FAIL mid_rst_rev got=%b exp=0", seq_rev); end
        total++; if (loss !== 1'b0) begin bad++; $display("FAIL mid_rst_loss got=%b exp=0", loss); end
        total++; if (period !== 16'd0) begin bad++; $display("FAIL mid_rst_period got=%0d exp=0", period); end
    endtask

    task automatic test_enable;
        lock_fwd();
        total++; if (seq_fwd !== 1'b1) begin bad++; $display("FAIL en_lock got=%b exp=1", seq_fwd); end
        en = 1'b0;
        idle(1);
        total++; if (seq_fwd !== 1'b0) begin bad++; $display("FAIL en_low_fwd got=%b exp=0", seq_fwd); end
        en = 1'b1;
        fire(0, 1, 0);
        total++; if (seq_fwd !== 1'b0) begin bad++; $display("FAIL en_after_fwd got=%b exp=0", seq_fwd); end
        total++; if (glitch !== 1'b0) begin bad++; $display("FAIL en_after_glitch got=%b exp=0", glitch); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reversal();
        test_loss();
        test_glitch();
        test_reset_midlock();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
